instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter DATA_WIDTH, 32, instruction and memory data width.
REQ-002 Parameter ADDR_WIDTH, 32, program counter and memory address width.
REQ-003 Parameter FIFO_DEPTH, 4, prefetch buffer entries; power of two, at least 2.
REQ-004 Parameter RESET_PC, 0, fetch address after reset.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 arst_n  input  1  reset; asynchronous, active-low.
REQ-007 fetch_en  input  1  high permits new memory requests.
REQ-008 redirect_valid  input  1  branch/jump redirect strobe, one cycle.
REQ-009 redirect_pc  input  ADDR_WIDTH  redirect target.
REQ-010 mem_req_valid  output  1  memory read request.
REQ-011 mem_req_addr  output  ADDR_WIDTH  request address.
REQ-012 mem_req_ready  input  1  memory accepts request.
REQ-013 mem_rsp_valid  input  1  read data valid; in-order; no backpressure.
REQ-014 mem_rsp_data  input  DATA_WIDTH  read data.
REQ-015 instr_valid  output  1  instruction available to core.
REQ-016 instr_ready  input  1  core consumes instruction.
REQ-017 instruction  output  DATA_WIDTH  instruction word to core decode/control unit.
REQ-018 instr_pc  output  ADDR_WIDTH  address of the presented instruction.

Function
REQ-019 fetch_pc register drives mem_req_addr; rsp_pc register tracks address of next expected response.
REQ-020 FSM states: RUN, FLUSH.
REQ-021 mem_req_valid high only when state RUN, fetch_en high, redirect_valid low, and fifo_count + outstanding < FIFO_DEPTH.
REQ-022 Request accepted when mem_req_valid and mem_req_ready: fetch_pc <= fetch_pc + 4 (mod 2^ADDR_WIDTH), outstanding +1.
REQ-023 mem_req_valid and mem_req_addr stay stable until accepted unless redirect occurs.
REQ-024 Response in RUN: push {rsp_pc, mem_rsp_data} into FIFO, rsp_pc +4, outstanding -1; never overflows given REQ-021.
REQ-025 FIFO head drives instr_valid/instruction/instr_pc; pop on instr_valid and instr_ready; push and pop in the same cycle both occur, count unchanged.
REQ-026 Latency: response in cycle N visible at instr_valid in cycle N+1 when FIFO empty.
REQ-027 Redirect (any state): FIFO flushed next cycle, fetch_pc and rsp_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}, discard <= outstanding after this cycle's response accounting.
REQ-028 Redirect: state <= FLUSH if discard nonzero, else RUN.
REQ-029 Pop in the same cycle as redirect completes for the consumer; response in same cycle as redirect is discarded.
REQ-030 FLUSH: no requests; each response decrements discard and outstanding, data dropped; discard reaching 0 -> RUN next cycle.
REQ-031 Redirect during FLUSH updates PCs; remains FLUSH until all stale responses drained.
REQ-032 fetch_en low: no new requests; outstanding responses still accepted and buffered.
REQ-033 fetch_pc wraps from 2^ADDR_WIDTH-4 to 0 without error.

Reset
REQ-034 arst_n low asynchronously: state RUN, fetch_pc and rsp_pc RESET_PC, fifo_count, outstanding, discard 0.
REQ-035 During reset: mem_req_valid 0, instr_valid 0, instruction 0, instr_pc 0.
REQ-036 Reset mid-transaction abandons outstanding requests; memory model is reset with the block.
REQ-037 First request issued in the first cycle after arst_n deasserts with fetch_en high, address RESET_PC.

Verification
REQ-038 Reset release, fetch_en=1, 1-cycle memory returning addr*2 -> instructions at pc 0,4,8,12 with data 0,8,16,24, no gaps.
REQ-039 instr_ready held low -> exactly 4 requests issued, instr_valid high, pc 0 held; ready raised -> 0,4,8,12,16 in order.
REQ-040 3-cycle memory latency, 2 requests outstanding, redirect_pc=0x103 -> state FLUSH, 2 responses dropped, next instr_pc 0x100.
REQ-041 Redirect coinciding with response and pop -> popped instruction consumed once, response dropped, next instr_pc equals redirect target.
REQ-042 RESET_PC=0xFFFFFFF8 -> instr_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-043 arst_n pulsed low with 3 outstanding -> all outputs at reset values within the pulse; restart at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Prefetching instruction fetch front end. Issues sequential word reads
// starting at RESET_PC, buffers in-order responses together with their
// addresses in a small FIFO, and presents them to the core. A redirect
// re-targets both the request and response address streams. Any reads still
// in flight at that point are marked stale and are dropped as they return.
module instr_fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0] instr_pc
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                state, state_nxt;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] rsp_pc;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W-1:0]      outstanding;
  logic [CNT_W-1:0]      discard;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;

  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];

  logic [ADDR_WIDTH-1:0] redirect_tgt;
  logic [CNT_W:0]        in_flight;
  logic                  credit_ok;
  logic                  req_ok;
  logic                  req_fire;
  logic                  rsp_keep;
  logic                  pop;
  logic [CNT_W-1:0]      out_after_rsp;

  // Redirect targets are forced to word alignment.
  assign redirect_tgt  = redirect_pc & ~ADDR_WIDTH'(3);

  // Buffered words plus reads in flight must never exceed the FIFO size,
  // so every response is guaranteed a slot and the memory needs no
  // backpressure.
  assign in_flight     = {1'b0, fifo_count} + {1'b0, outstanding};
  assign credit_ok     = in_flight < (CNT_W + 1)'(FIFO_DEPTH);

  // Reset only masks the port; internal state is already held by the
  // asynchronous clear, so the first request can leave in the very first
  // cycle after release.
  assign mem_req_valid = req_ok & arst_n;
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = req_ok & mem_req_ready;

  // A response is kept only in RUN and only when no redirect makes it stale.
  assign rsp_keep      = mem_rsp_valid & (state == RUN) & ~redirect_valid;
  assign pop           = instr_valid & instr_ready;

  // In-flight count once this cycle's response is accounted for; on a
  // redirect this is exactly the number of stale reads still to come back.
  assign out_after_rsp = outstanding - CNT_W'(mem_rsp_valid);

  assign instr_valid   = (fifo_count != '0);
  assign instruction   = instr_valid ? fifo_data[rd_ptr] : '0;
  assign instr_pc      = instr_valid ? fifo_pc[rd_ptr]   : '0;

  // State register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and request permission.
  always_comb begin
    state_nxt = state;
    req_ok    = 1'b0;
    if (state == RUN) begin
      req_ok = fetch_en & ~redirect_valid & credit_ok;
    end
    if (redirect_valid) begin
      state_nxt = (out_after_rsp != '0) ? FLUSH : RUN;
    end else if (state == FLUSH) begin
      if (discard == '0) begin
        state_nxt = RUN;
      end else if (mem_rsp_valid && (discard == CNT_W'(1))) begin
        state_nxt = RUN;
      end
    end
  end

  // Request and response address streams.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_tgt;
      rsp_pc   <= redirect_tgt;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
      end
      if (rsp_keep) begin
        rsp_pc <= rsp_pc + ADDR_WIDTH'(4);
      end
    end
  end

  // In-flight read count and the number of stale reads still to drop.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= out_after_rsp + CNT_W'(req_fire);
      if (redirect_valid) begin
        discard <= out_after_rsp;
      end else if ((state == FLUSH) && mem_rsp_valid && (discard != '0)) begin
        discard <= discard - CNT_W'(1);
      end
    end
  end

  // FIFO occupancy and pointers; a redirect empties the buffer.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      fifo_count <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else if (redirect_valid) begin
      fifo_count <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      if (rsp_keep) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_count <= fifo_count + CNT_W'(rsp_keep) - CNT_W'(pop);
    end
  end

  // FIFO storage; contents are qualified by fifo_count and need no reset.
  always_ff @(posedge clk) begin
    if (rsp_keep) begin
      fifo_data[wr_ptr] <= mem_rsp_data;
      fifo_pc[wr_ptr]   <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios, a stream-level reference
// model checked every cycle, and literal expectations per scenario.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  // second instance near the top of the address space
  logic        w_fetch_en;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_req_ready;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_instr_valid;
  logic        w_instr_ready;
  logic [31:0] w_instruction;
  logic [31:0] w_instr_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .FIFO_DEPTH(DEPTH), .RESET_PC(32'h0)
  ) u_dut (
    .clk(clk), .arst_n(arst_n), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instruction(instruction), .instr_pc(instr_pc)
  );

  instr_fetch_unit #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .FIFO_DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)
  ) u_wrap (
    .clk(clk), .arst_n(arst_n), .fetch_en(w_fetch_en),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .mem_req_valid(w_req_valid), .mem_req_addr(w_req_addr),
    .mem_req_ready(w_req_ready), .mem_rsp_valid(w_rsp_valid),
    .mem_rsp_data(w_rsp_data), .instr_valid(w_instr_valid),
    .instr_ready(w_instr_ready), .instruction(w_instruction), .instr_pc(w_instr_pc)
  );

  typedef struct packed { logic [31:0] addr; logic [31:0] due; } mreq_t;
  typedef struct packed { logic [31:0] pc; logic [31:0] data; logic [31:0] cyc; } ev_t;

  int          n_chk;
  int          n_pass;
  int          cyc;
  int          rel;
  int          lat;
  int          avail;     // words the core should currently see buffered
  int          stale;     // reads in flight that belong to an abandoned stream
  int          dropped;   // responses the model says must be thrown away
  logic [31:0] exp_pc;
  logic [31:0] exp_req_addr;
  mreq_t       mq[$];
  ev_t         pops[$];
  ev_t         reqs[$];
  logic        w_next_valid;
  logic [31:0] w_next_data;
  logic [31:0] w_pcs[$];
  logic [31:0] w_dat[$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endfunction

  function automatic logic [31:0] pop_pc(input int i);
    return (i < pops.size()) ? pops[i].pc : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] pop_data(input int i);
    return (i < pops.size()) ? pops[i].data : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] pop_cyc(input int i);
    return (i < pops.size()) ? pops[i].cyc : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] req_addr(input int i);
    return (i < reqs.size()) ? reqs[i].pc : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] req_cyc(input int i);
    return (i < reqs.size()) ? reqs[i].cyc : 32'hxxxx_xxxx;
  endfunction

  // Sampled at the falling edge: compare against the model, then advance it
  // with what will happen at the next rising edge.
  task automatic model_step();
    mreq_t       e;
    ev_t         ev;
    logic [31:0] tgt;
    logic        exp_req;
    if (!arst_n) begin
      chk("rst_mem_req_valid", mem_req_valid, 0);
      chk("rst_instr_valid", instr_valid, 0);
      chk("rst_instruction", instruction, 0);
      chk("rst_instr_pc", instr_pc, 0);
      chk("rst_wrap_req_valid", w_req_valid, 0);
      exp_pc       = 32'h0;
      exp_req_addr = 32'h0;
      avail        = 0;
      stale        = 0;
      mq.delete();
      w_next_valid = 1'b0;
      w_next_data  = 32'h0;
      return;
    end
    chk("instr_valid", instr_valid, avail != 0);
    if (instr_valid && (avail != 0)) begin
      chk("instr_pc", instr_pc, exp_pc);
      chk("instruction", instruction, exp_pc << 1);
    end
    exp_req = fetch_en && !redirect_valid && (stale == 0) && ((avail + mq.size()) < DEPTH);
    chk("mem_req_valid", mem_req_valid, exp_req);
    if (mem_req_valid) chk("mem_req_addr", mem_req_addr, exp_req_addr);
    if (mem_req_valid && mem_req_ready) begin
      e.addr = mem_req_addr;
      e.due  = 32'(cyc + lat);
      mq.push_back(e);
      ev.pc = mem_req_addr; ev.data = 32'h0; ev.cyc = 32'(cyc);
      reqs.push_back(ev);
      exp_req_addr = exp_req_addr + 32'd4;
    end
    if (instr_valid && instr_ready) begin
      ev.pc = instr_pc; ev.data = instruction; ev.cyc = 32'(cyc);
      pops.push_back(ev);
      exp_pc = exp_pc + 32'd4;
      if (avail > 0) avail--;
    end
    if (mem_rsp_valid) begin
      if (mq.size() > 0) void'(mq.pop_front());
      if (redirect_valid) dropped++;
      else if (stale > 0) begin stale--; dropped++; end
      else avail++;
    end
    if (redirect_valid) begin
      tgt          = redirect_pc & 32'hFFFF_FFFC;
      exp_pc       = tgt;
      exp_req_addr = tgt;
      avail        = 0;
      stale        = mq.size();
    end
    if (w_instr_valid && (w_pcs.size() < 3)) begin
      w_pcs.push_back(w_instr_pc);
      w_dat.push_back(w_instruction);
    end
    w_next_valid = w_req_valid & w_req_ready;
    w_next_data  = w_req_addr << 1;
  endtask

  // Memory models drive their responses just after the rising edge.
  task automatic drive_mem();
    if (!arst_n) begin
      mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
      w_rsp_valid   = 1'b0; w_rsp_data   = 32'h0;
    end else begin
      if ((mq.size() > 0) && (mq[0].due <= 32'(cyc))) begin
        mem_rsp_valid = 1'b1; mem_rsp_data = mq[0].addr << 1;
      end else begin
        mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
      end
      w_rsp_valid = w_next_valid;
      w_rsp_data  = w_next_data;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    drive_mem();
  endtask

  task automatic do_reset(input int n);
    arst_n = 1'b0;
    repeat (n) tick();
    arst_n = 1'b1;
    rel = cyc;
    pops.delete();
    reqs.delete();
    dropped = 0;
  endtask

  logic [31:0] exp_a_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
  logic [31:0] exp_a_dat[4] = '{32'h0, 32'h8, 32'h10, 32'h18};
  logic [31:0] exp_w_pc [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
  logic [31:0] exp_w_dat[3] = '{32'hFFFF_FFF0, 32'hFFFF_FFF8, 32'h0};
  logic [31:0] exp_b_pc [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
  logic [31:0] exp_d_pc [5] = '{32'h0, 32'h4, 32'h8, 32'h200, 32'h204};

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; rel = 0; lat = 1;
    avail = 0; stale = 0; dropped = 0; exp_pc = 0; exp_req_addr = 0;
    w_next_valid = 1'b0; w_next_data = 32'h0;
    arst_n = 1'b0; fetch_en = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0; instr_ready = 1'b1;
    w_fetch_en = 1'b1; w_redirect_valid = 1'b0; w_redirect_pc = 32'h0; w_req_ready = 1'b1;
    w_rsp_valid = 1'b0; w_rsp_data = 32'h0; w_instr_ready = 1'b1;

    // A: streaming with a 1-cycle memory, plus address wrap on the second unit
    do_reset(3);
    repeat (8) tick();
    chk("a_first_req_cyc", req_cyc(0), 32'(rel));
    chk("a_first_req_addr", req_addr(0), 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("a_pc%0d", i), pop_pc(i), exp_a_pc[i]);
      chk($sformatf("a_data%0d", i), pop_data(i), exp_a_dat[i]);
      chk($sformatf("a_cyc%0d", i), pop_cyc(i), 32'(rel + 2 + i));
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("wrap_pc%0d", i), (i < w_pcs.size()) ? w_pcs[i] : 32'hxxxx_xxxx, exp_w_pc[i]);
      chk($sformatf("wrap_data%0d", i), (i < w_dat.size()) ? w_dat[i] : 32'hxxxx_xxxx, exp_w_dat[i]);
    end

    // B: consumer stalled fills the buffer, then drains in order
    instr_ready = 1'b0;
    do_reset(2);
    repeat (10) tick();
    chk("b_req_count", reqs.size(), 4);
    chk("b_valid_held", instr_valid, 1);
    chk("b_pc_held", instr_pc, 32'h0);
    instr_ready = 1'b1;
    repeat (10) tick();
    for (int i = 0; i < 5; i++) chk($sformatf("b_pc%0d", i), pop_pc(i), exp_b_pc[i]);

    // C: redirect with two reads in flight on a 3-cycle memory
    lat = 3;
    do_reset(2);
    repeat (2) tick();
    fetch_en = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect_valid = 1'b0; fetch_en = 1'b1;
    reqs.delete(); pops.delete();
    repeat (10) tick();
    chk("c_dropped", dropped, 2);
    chk("c_req_addr", req_addr(0), 32'h100);
    chk("c_req_cyc", req_cyc(0), 32'(rel + 5));
    chk("c_pop_pc", pop_pc(0), 32'h100);
    chk("c_pop_data", pop_data(0), 32'h200);
    chk("c_pop_cyc", pop_cyc(0), 32'(rel + 9));

    // D: redirect in the same cycle as a response and a pop
    lat = 1;
    do_reset(2);
    repeat (4) tick();
    dropped = 0;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    repeat (6) tick();
    for (int i = 0; i < 5; i++) chk($sformatf("d_pc%0d", i), pop_pc(i), exp_d_pc[i]);
    chk("d_pop_on_redirect_cyc", pop_cyc(2), 32'(rel + 4));
    chk("d_dropped", dropped, 1);

    // E: asynchronous reset pulse with three reads in flight
    lat = 3;
    do_reset(2);
    repeat (9) tick();
    chk("e_pre_valid", instr_valid, 1);
    chk("e_pre_pc", instr_pc, 32'h10);
    chk("e_pre_data", instruction, 32'h20);
    #2;
    arst_n = 1'b0;
    #1;
    chk("e_pulse_req_valid", mem_req_valid, 0);
    chk("e_pulse_instr_valid", instr_valid, 0);
    chk("e_pulse_instruction", instruction, 0);
    chk("e_pulse_instr_pc", instr_pc, 0);
    repeat (2) tick();
    arst_n = 1'b1;
    rel = cyc;
    pops.delete(); reqs.delete();
    repeat (6) tick();
    chk("e_restart_addr", req_addr(0), 32'h0);
    chk("e_restart_cyc", req_cyc(0), 32'(rel));
    chk("e_restart_pop_pc", pop_pc(0), 32'h0);
    chk("e_restart_pop_cyc", pop_cyc(0), 32'(rel + 4));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
